lenet_frame_reader: RTL and testbench

//  Read side of the LeNet input buffer (fb3, port B, clk100 domain): after a start pulse, walks the 28x28 accumulated-pixel
//  map from address 0, reads each 16-bit word and streams each one out as an 8-bit pixel. Output uses a valid/ready

---
 rtl/lenet_pkg.sv | 31 +++
 rtl/lenet_skid_fifo.sv | 52 +++++
 rtl/lenet_frame_reader.sv | 125 ++++++++++++
 tb/tb_lenet_frame_reader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// Shared types and sizes for the LeNet input-buffer read path (fb3 port B side).
// The pixel conversion lives here so the datapath and any future writer agree on scaling.
package lenet_pkg;

    localparam int LENET_SIZE = 28;
    localparam int LENET_PIX  = LENET_SIZE ** 2;
    localparam int ADDR_W     = 10;
    localparam int MEM_W      = 16;
    localparam int ACC_W      = 10;
    localparam int PIX_W      = 8;
    localparam int COL_W      = $clog2(LENET_SIZE);

    typedef enum logic [1:0] {RD_IDLE, RD_RUN, RD_DRAIN, RD_DONE} rd_state_t;

    typedef struct packed {
        logic [PIX_W-1:0] pix;
        logic             row_last;
        logic             last;
    } lenet_beat_t;

    // Accumulated value scaled down to pixel range, clamped at full scale.
    function automatic logic [PIX_W-1:0] acc_to_pix(input logic [ACC_W-1:0] acc);
        logic [ACC_W-1:0] shifted;
        shifted = acc >> (ACC_W - PIX_W);
        if (shifted > ACC_W'((1 << PIX_W) - 1)) begin
            return '1;
        end
        return shifted[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/lenet_skid_fifo.sv
// Two-entry beat FIFO sitting between the fb3 read return and the pixel stream.
// The head entry only moves on a pop, which keeps the output stable while stalled.
module lenet_skid_fifo
    import lenet_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_flush,
    input  logic        i_push,
    input  lenet_beat_t i_data,
    input  logic        i_pop,
    output lenet_beat_t o_head,
    output logic [1:0]  o_count
);

    lenet_beat_t r_mem [2];
    logic        r_wptr;
    logic        r_rptr;
    logic [1:0]  r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset as well so the pixel outputs read 0 straight out of reset.
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            if (i_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: ;
            endcase
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/lenet_frame_reader.sv
// Walks the 28x28 accumulated map in fb3 and streams it as 8-bit pixels with row/frame markers.
// One read may be in flight; the FIFO plus that read never exceed two beats.
module lenet_frame_reader
    import lenet_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ren,
    input  logic [MEM_W-1:0]  mem_rdata,
    output logic [PIX_W-1:0]  m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_row_last,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    rd_state_t         r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_pix_idx;
    logic [COL_W-1:0]  r_col;
    logic              r_rd_pend;
    logic              r_busy;
    logic              r_done;

    logic              w_pop;
    logic              w_issue;
    logic              w_final;
    logic [2:0]        w_occ;
    logic [1:0]        w_count;
    lenet_beat_t       w_beat_in;
    lenet_beat_t       w_head;
    logic              w_unused_low;

    // Counting this cycle's pop lets a read refill the slot being freed, giving 1 pixel/cycle.
    assign w_pop   = m_valid && m_ready;
    assign w_occ   = {1'b0, w_count} - {2'b00, w_pop} + {2'b00, r_rd_pend};
    assign w_issue = (r_state == RD_RUN) && !abort && (w_occ < 3'd2);
    assign w_final = (r_state == RD_DRAIN) && w_pop && w_head.last;

    assign w_beat_in = '{
        pix:      acc_to_pix(mem_rdata[MEM_W-1 -: ACC_W]),
        row_last: (r_col == COL_W'(LENET_SIZE - 1)),
        last:     (r_pix_idx == ADDR_W'(LENET_PIX - 1))
    };
    assign w_unused_low = ^mem_rdata[MEM_W-ACC_W-1:0];

    lenet_skid_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (abort),
        .i_push  (r_rd_pend),
        .i_data  (w_beat_in),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RD_IDLE;
            r_addr    <= '0;
            r_pix_idx <= '0;
            r_col     <= '0;
            r_rd_pend <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (abort) begin
            r_state   <= RD_IDLE;
            r_rd_pend <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_rd_pend <= w_issue;
            r_done    <= 1'b0;
            if (r_rd_pend) begin
                r_pix_idx <= r_pix_idx + 1'b1;
                r_col     <= (r_col == COL_W'(LENET_SIZE - 1)) ? '0 : r_col + 1'b1;
            end
            case (r_state)
                RD_IDLE: begin
                    if (start) begin
                        r_state   <= RD_RUN;
                        r_addr    <= '0;
                        r_pix_idx <= '0;
                        r_col     <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                RD_RUN: begin
                    if (w_issue) begin
                        if (r_addr == ADDR_W'(LENET_PIX - 1)) begin
                            r_state <= RD_DRAIN;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end
                RD_DRAIN: begin
                    if (w_final) begin
                        r_state <= RD_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                RD_DONE: r_state <= RD_IDLE;
                default: r_state <= RD_IDLE;
            endcase
        end
    end

    assign mem_addr   = r_addr;
    assign mem_ren    = w_issue;
    assign m_data     = w_head.pix;
    assign m_valid    = (w_count != 2'd0);
    assign m_row_last = w_head.row_last;
    assign m_last     = w_head.last;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_lenet_frame_reader.sv
// Scoreboard bench for lenet_frame_reader: stimulus queues expected beats, a negedge monitor checks them.
// The reference derives pixels from the word value arithmetically and flags from the pixel index.
module tb_lenet_frame_reader;
    import lenet_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              m_ready = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ren;
    logic [MEM_W-1:0]  mem_rdata;
    logic [PIX_W-1:0]  m_data;
    logic              m_valid;
    logic              m_row_last;
    logic              m_last;
    logic              busy;
    logic              done;

    logic [MEM_W-1:0]  mem_arr [LENET_PIX];
    lenet_beat_t       exp_q [$];
    int                n_checks = 0;
    int                n_fail = 0;
    int                cyc = 0;
    int                done_cnt = 0;
    int                accepted = 0;
    int                ready_mode = 0;

    lenet_frame_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .mem_addr   (mem_addr),
        .mem_ren    (mem_ren),
        .mem_rdata  (mem_rdata),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_row_last (m_row_last),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_ren && mem_addr < LENET_PIX) mem_rdata <= mem_arr[mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic lenet_beat_t ref_beat(input int i);
        lenet_beat_t b;
        int acc;
        int p;
        acc = int'(mem_arr[i]) / 64;
        p = acc / 4;
        if (p > 255) p = 255;
        b.pix      = PIX_W'(p);
        b.row_last = (i % LENET_SIZE) == LENET_SIZE - 1;
        b.last     = (i == LENET_PIX - 1);
        return b;
    endfunction

    // Monitor / scoreboard
    lenet_beat_t got;
    lenet_beat_t prev_beat;
    lenet_beat_t exp_b;
    bit prev_stall = 0, prev_abort = 0, done_due = 0, first_pending = 0, ren_pending = 0;
    int start_cyc = 0, exp_addr = 0, issued = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0; done_due = 0; first_pending = 0; ren_pending = 0;
        end else begin
            got = '{pix: m_data, row_last: m_row_last, last: m_last};
            if (done || done_due) check("done_pulse", 32'(done), 32'(done_due));
            if (done) done_cnt++;
            done_due = 0;
            if (prev_stall && !prev_abort) begin
                check("stall_valid_held", 32'(m_valid), 32'd1);
                check("stall_beat_held", 32'(got), 32'(prev_beat));
            end
            if (start && !busy && !abort) begin
                start_cyc = cyc; first_pending = 1; ren_pending = 1;
                exp_addr = 0; issued = 0; accepted = 0;
            end
            if (mem_ren) begin
                if (ren_pending) begin
                    check("first_ren_latency", 32'(cyc - start_cyc), 32'd1);
                    ren_pending = 0;
                end
                check("mem_addr", 32'(mem_addr), 32'(exp_addr));
                exp_addr++;
                issued++;
                check("outstanding_le2", 32'((issued - accepted - int'(m_valid && m_ready)) <= 2), 32'd1);
            end
            if (m_valid && first_pending) begin
                check("first_valid_latency", 32'(cyc - start_cyc), 32'd3);
                first_pending = 0;
            end
            if (m_valid && m_ready) begin
                accepted++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(got), 32'hFFFF_FFFF);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("beat", 32'(got), 32'(exp_b));
                end
                if (m_last) done_due = 1;
            end
            prev_stall = m_valid && !m_ready;
            prev_beat  = got;
            prev_abort = abort;
        end
    end

    // Stimulus
    task automatic tick();
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
    endtask

    task automatic start_frame();
        tick();
        start = 1'b1;
        for (int i = 0; i < LENET_PIX; i++) exp_q.push_back(ref_beat(i));
        tick();
        start = 1'b0;
    endtask

    task automatic wait_frame(input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        check("frame_complete", 32'(done_cnt != d0), 32'd1);
        repeat (3) tick();
        check("single_done", 32'(done_cnt - d0), 32'd1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_ren"}, 32'(mem_ren), 32'd0);
        check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_m_data"}, 32'(m_data), 32'd0);
        check({tag, "_m_row_last"}, 32'(m_row_last), 32'd0);
        check({tag, "_m_last"}, 32'(m_last), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < LENET_PIX; i++) mem_arr[i] = MEM_W'(i * 64);
    endtask

    initial begin
        int n;
        int d0;
        fill_ramp();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Ramp frame, consumer always ready
        ready_mode = 0;
        start_frame();
        wait_frame(3000);

        // Same frame under random backpressure
        ready_mode = 1;
        start_frame();
        wait_frame(6000);

        // Random words plus saturation and ignored-low-bit corners
        for (int i = 0; i < LENET_PIX; i++) mem_arr[i] = MEM_W'($urandom);
        mem_arr[0]  = 16'hFFC0;
        mem_arr[1]  = 16'h003F;
        mem_arr[27] = 16'hFFFF;
        start_frame();
        wait_frame(6000);

        // Abort after 100 handshakes, then restart from pixel 0
        fill_ramp();
        start_frame();
        n = 0;
        while (accepted < 100 && n < 5000) begin
            tick();
            n++;
        end
        check("abort_point_reached", 32'(accepted), 32'd100);
        d0 = done_cnt;
        ready_mode = 2;
        m_ready = 1'b0;
        abort = 1'b1;
        exp_q.delete();
        tick();
        abort = 1'b0;
        check("abort_m_valid", 32'(m_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (4) begin
            tick();
            check("abort_no_late_valid", 32'(m_valid), 32'd0);
        end
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        ready_mode = 1;
        start_frame();
        wait_frame(6000);

        // Start while busy and start together with abort are both ignored
        start_frame();
        repeat (50) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_frame(6000);
        d0 = done_cnt;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        repeat (4) begin
            check("start_abort_busy", 32'(busy), 32'd0);
            check("start_abort_ren", 32'(mem_ren), 32'd0);
            tick();
        end
        check("start_abort_no_done", 32'(done_cnt - d0), 32'd0);

        // Asynchronous reset mid-frame while stalled
        start_frame();
        repeat (200) tick();
        ready_mode = 2;
        m_ready = 1'b0;
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        ready_mode = 0;
        start_frame();
        wait_frame(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
